key_scan_debounce: RTL and testbench

- Input-side counterpart of the board LED pattern driver. It reads the board's active-low push-buttons and DIP switches, synchronises and debounces them, and publishes a clean active-high switch state.
- Each committed change is also issued as an edge event (rise/fall masks) on a valid/ready handshake. A pattern-select FSM or a test controller consumes it.
- Sits directly behind the FPGA pins in the same clock domain (50 MHz board clock).

---
 rtl/key_scan_debounce.sv | 116 +++++++++++
 tb/tb_key_scan_debounce.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/key_scan_debounce.sv
// Debounces active-low board keys/switches into a clean active-high state.
// Each committed change is also published as a rise/fall edge event on a valid/ready handshake.
module key_scan_debounce #(
    parameter int          WIDTH      = 16,
    parameter logic [31:0] STABLE_CNT = 32'd500_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_n,
    output logic [WIDTH-1:0] sw_state,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_rise,
    output logic [WIDTH-1:0] evt_fall,
    output logic             evt_overrun
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CHECK  = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    logic [1:0]       state;
    logic [31:0]      cnt;
    logic [WIDTH-1:0] sync1_n;
    logic [WIDTH-1:0] sync2_n;
    logic [WIDTH-1:0] syn;
    logic [WIDTH-1:0] candidate;
    logic [WIDTH-1:0] new_rise;
    logic [WIDTH-1:0] new_fall;
    logic             commit;
    logic             transfer;

    // The pins are sampled raw and inverted only after the second flop. The flops reset
    // high, so syn reads as "nothing pressed" while reset is applied.
    // NOTE: all sequential state uses non-blocking assignments so that every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_n <= '1;
            sync2_n <= '1;
        end else begin
            sync1_n <= sw_n;
            sync2_n <= sync1_n;
        end
    end

    assign syn      = ~sync2_n;
    assign commit   = (state == COMMIT);
    assign transfer = evt_valid & evt_ready;
    assign new_rise = candidate & ~sw_state;
    assign new_fall = ~candidate & sw_state;

    // Any bit that moves inside the window restarts the window for the whole word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            candidate <= '0;
            sw_state  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (syn != sw_state) begin
                        candidate <= syn;
                        state     <= CHECK;
                    end
                end
                CHECK: begin
                    if (syn == sw_state) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (syn != candidate) begin
                        candidate <= syn;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                        if (cnt == STABLE_CNT - 32'd1) state <= COMMIT;
                    end
                end
                COMMIT: begin
                    sw_state <= candidate;
                    cnt      <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A commit landing on an unaccepted event is merged into it and flagged as overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid   <= 1'b0;
            evt_rise    <= '0;
            evt_fall    <= '0;
            evt_overrun <= 1'b0;
        end else if (commit) begin
            evt_valid <= 1'b1;
            if (!evt_valid || transfer) begin
                evt_rise    <= new_rise;
                evt_fall    <= new_fall;
                evt_overrun <= 1'b0;
            end else begin
                evt_rise    <= evt_rise | new_rise;
                evt_fall    <= evt_fall | new_fall;
                evt_overrun <= 1'b1;
            end
        end else if (transfer) begin
            evt_valid   <= 1'b0;
            evt_rise    <= '0;
            evt_fall    <= '0;
            evt_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_key_scan_debounce.sv
// Bench for key_scan_debounce: a window-timing model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_key_scan_debounce;

    localparam int          WIDTH = 16;
    localparam int          S     = 8;
    localparam logic [31:0] SC    = 32'd8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] sw_n;
    logic [WIDTH-1:0] sw_state;
    logic             evt_valid;
    logic             evt_ready;
    logic [WIDTH-1:0] evt_rise;
    logic [WIDTH-1:0] evt_fall;
    logic             evt_overrun;

    int n_cmp  = 0;
    int n_fail = 0;

    key_scan_debounce #(.WIDTH(WIDTH), .STABLE_CNT(SC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_n       (sw_n),
        .sw_state   (sw_state),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_rise   (evt_rise),
        .evt_fall   (evt_fall),
        .evt_overrun(evt_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the synchronised input lags the pins by two edges; a window opened at edge
    // m_start commits on edge m_start+S+1 if the candidate holds unbroken until then.
    logic [WIDTH-1:0] m_s1, m_syn, m_state, m_cand, m_rise, m_fall;
    logic             m_busy, m_commit, m_valid, m_over;
    int               m_n, m_start;

    initial begin
        m_s1 = '0; m_syn = '0; m_state = '0; m_cand = '0; m_rise = '0; m_fall = '0;
        m_busy = 0; m_commit = 0; m_valid = 0; m_over = 0; m_n = 0; m_start = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_s1 = '0; m_syn = '0; m_state = '0; m_cand = '0; m_rise = '0; m_fall = '0;
                m_busy = 0; m_commit = 0; m_valid = 0; m_over = 0;
            end else begin
                logic [WIDTH-1:0] nr, nf;
                logic             did;
                nr = '0; nf = '0; did = 0;
                m_n++;
                if (m_commit) begin
                    did = 1;
                    nr = m_cand & ~m_state;
                    nf = ~m_cand & m_state;
                    m_state = m_cand;
                    m_commit = 0;
                    m_busy = 0;
                end else if (!m_busy) begin
                    if (m_syn != m_state) begin
                        m_busy = 1; m_cand = m_syn; m_start = m_n;
                    end
                end else if (m_syn == m_state) begin
                    m_busy = 0;
                end else if (m_syn != m_cand) begin
                    m_cand = m_syn; m_start = m_n;
                end else if (m_n - m_start == S) begin
                    m_commit = 1;
                end
                if (did) begin
                    if (!m_valid || evt_ready) begin
                        m_rise = nr; m_fall = nf; m_over = 0;
                    end else begin
                        m_rise |= nr; m_fall |= nf; m_over = 1;
                    end
                    m_valid = 1;
                end else if (m_valid && evt_ready) begin
                    m_valid = 0; m_rise = '0; m_fall = '0; m_over = 0;
                end
                m_syn = m_s1;
                m_s1  = ~sw_n;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("m_sw_state", 32'(sw_state), 32'(m_state));
            check("m_evt_valid", 32'(evt_valid), 32'(m_valid));
            check("m_evt_rise", 32'(evt_rise), 32'(m_rise));
            check("m_evt_fall", 32'(evt_fall), 32'(m_fall));
            check("m_evt_overrun", 32'(evt_overrun), 32'(m_over));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic accept();
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        check("accept_clears_valid", 32'(evt_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; sw_n = 16'h0000; evt_ready = 1'b0;

        // 1: reset with every key pressed
        tick(3);
        check("rst_sw_state", 32'(sw_state), 32'h0);
        check("rst_evt_valid", 32'(evt_valid), 32'h0);
        rst_n = 1'b1;
        tick(11);
        check("rst_edge11_state", 32'(sw_state), 32'h0);
        tick(1);
        check("rst_edge12_state", 32'(sw_state), 32'hFFFF);
        check("rst_edge12_valid", 32'(evt_valid), 32'h1);
        check("rst_edge12_rise", 32'(evt_rise), 32'hFFFF);
        check("rst_edge12_fall", 32'(evt_fall), 32'h0);
        accept();

        // 2: release everything, then a clean press of bit 0
        sw_n = 16'hFFFF;
        tick(14);
        check("release_state", 32'(sw_state), 32'h0);
        check("release_fall", 32'(evt_fall), 32'hFFFF);
        accept();
        sw_n = 16'hFFFE;
        tick(11);
        check("press_edge11_state", 32'(sw_state), 32'h0);
        tick(1);
        check("press_edge12_state", 32'(sw_state), 32'h0001);
        check("press_edge12_valid", 32'(evt_valid), 32'h1);
        check("press_edge12_rise", 32'(evt_rise), 32'h0001);
        accept();

        // 3: bit 3 bounces every 5 cycles, then settles pressed
        for (int i = 0; i <= 8; i++) begin
            sw_n = (i % 2 == 0) ? 16'hFFF6 : 16'hFFFE;
            if (i < 8) begin
                tick(5);
                check("bounce_no_commit", 32'(evt_valid), 32'h0);
            end
        end
        tick(11);
        check("bounce_edge11_valid", 32'(evt_valid), 32'h0);
        tick(1);
        check("bounce_edge12_valid", 32'(evt_valid), 32'h1);
        check("bounce_rise", 32'(evt_rise), 32'h0008);
        check("bounce_state", 32'(sw_state), 32'h0009);
        accept();

        // 4: 6-cycle glitch on bit 7 is rejected
        sw_n = 16'hFF76;
        tick(6);
        sw_n = 16'hFFF6;
        tick(20);
        check("glitch_valid", 32'(evt_valid), 32'h0);
        check("glitch_state", 32'(sw_state), 32'h0009);

        // 5: three commits merged into one unaccepted event
        sw_n = 16'hFFFF;
        tick(14);
        accept();
        sw_n = 16'hFFFE; tick(14);
        sw_n = 16'hFFFF; tick(14);
        sw_n = 16'hFFFD; tick(14);
        check("merge_rise", 32'(evt_rise), 32'h0003);
        check("merge_fall", 32'(evt_fall), 32'h0001);
        check("merge_overrun", 32'(evt_overrun), 32'h1);
        check("merge_state", 32'(sw_state), 32'h0002);
        accept();
        check("merge_clr_rise", 32'(evt_rise), 32'h0);
        check("merge_clr_fall", 32'(evt_fall), 32'h0);
        check("merge_clr_overrun", 32'(evt_overrun), 32'h0);

        // 6: reset lands mid-window (cnt = 4), press re-debounces after release
        sw_n = 16'hFFDD;
        tick(7);
        rst_n = 1'b0;
        #1;
        check("midrst_state", 32'(sw_state), 32'h0);
        check("midrst_valid", 32'(evt_valid), 32'h0);
        tick(3);
        rst_n = 1'b1;
        tick(11);
        check("midrst_edge11_valid", 32'(evt_valid), 32'h0);
        tick(1);
        check("midrst_edge12_state", 32'(sw_state), 32'h0022);
        check("midrst_edge12_rise", 32'(evt_rise), 32'h0022);
        accept();

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
